// File: rtl/dram_seq_pkg.sv
// Shared constants and FSM encoding for the DRAM burst sequencer.
package dram_seq_pkg;

    localparam int unsigned BEAT_WIDTH  = 144;
    localparam int unsigned BURST_WIDTH = 2 * BEAT_WIDTH;
    localparam int unsigned BE_BEAT     = BEAT_WIDTH / 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWr2  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/dram_rd_assembler.sv
// Pairs the two read beats from the controller into one burst and flags beats
// that arrive while no read is outstanding.
module dram_rd_assembler
    import dram_seq_pkg::*;
#(
    parameter int unsigned BEAT_W = BEAT_WIDTH
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic [BEAT_W-1:0]   app_rd_data,
    input  logic                app_rd_valid,
    input  logic                rd_cnt_zero,
    output logic                rd_done,
    output logic [2*BEAT_W-1:0] usr_rd_data,
    output logic                usr_rd_valid,
    output logic                rd_unexpected
);

    logic                toggle_q, toggle_d;
    logic [BEAT_W-1:0]   low_q, low_d;
    logic [2*BEAT_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                unexp_q, unexp_d;

    assign rd_done = app_rd_valid & toggle_q;

    always_comb begin
        toggle_d = toggle_q;
        low_d    = low_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        unexp_d  = unexp_q;
        if (app_rd_valid) begin
            if (!toggle_q) begin
                low_d    = app_rd_data;
                toggle_d = 1'b1;
                // A stray beat is still assembled so the pairing stays in step.
                if (rd_cnt_zero) begin
                    unexp_d = 1'b1;
                end
            end else begin
                data_d   = {app_rd_data, low_q};
                valid_d  = 1'b1;
                toggle_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            toggle_q <= 1'b0;
            low_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            unexp_q  <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
            low_q    <= low_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            unexp_q  <= unexp_d;
        end
    end

    assign usr_rd_data   = data_q;
    assign usr_rd_valid  = valid_q;
    assign rd_unexpected = unexp_q;

endmodule

// File: rtl/dram_burst_sequencer.sv
// Front end for the DDR2 controller: splits user bursts into command + two write
// beats, gates issue, and reassembles reads. Statistics enabled by DRAM_SEQ_STATS_EN.
module dram_burst_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BEAT_WIDTH     = 144,
    parameter int unsigned MAX_RD_OUTSTND = 16,
    parameter int unsigned RD_CNT_W       = 5
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic                    phy_rdy,
    input  logic                    usr_cmd_valid,
    output logic                    usr_cmd_ready,
    input  logic                    usr_cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]   usr_cmd_addr,
    input  logic [2*BEAT_WIDTH-1:0] usr_wr_data,
    input  logic [BEAT_WIDTH/4-1:0] usr_wr_be,
    output logic [2*BEAT_WIDTH-1:0] usr_rd_data,
    output logic                    usr_rd_valid,
    output logic                    rd_unexpected,
    output logic [ADDR_WIDTH-1:0]   app_cmd_addr,
    output logic                    app_cmd_rnw,
    output logic                    app_cmd_valid,
    output logic [BEAT_WIDTH-1:0]   app_wr_data,
    output logic [BEAT_WIDTH/8-1:0] app_wr_be,
    input  logic [BEAT_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_valid,
    input  logic                    app_fifo_ready,
    output logic [31:0]             stat_wr_cnt,
    output logic [31:0]             stat_rd_cnt
);
    import dram_seq_pkg::*;

    localparam int unsigned BE_W = BEAT_WIDTH / 8;
    localparam logic [RD_CNT_W-1:0] MAX_CNT = RD_CNT_W'(MAX_RD_OUTSTND);

    seq_state_e            state_q, state_d;
    logic [RD_CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                  ready_q, ready_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rnw_q, rnw_d;
    logic [BEAT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [BE_W-1:0]       wr_be_q, wr_be_d;
    logic [BEAT_WIDTH-1:0] hi_data_q, hi_data_d;
    logic [BE_W-1:0]       hi_be_q, hi_be_d;

    logic accept;
    logic rd_issue;
    logic rd_done;
    logic rd_retire;

    assign accept    = usr_cmd_valid & ready_q;
    assign rd_issue  = accept & usr_cmd_rnw;
    // A stray second beat must not drag the counter below zero.
    assign rd_retire = rd_done & (rd_cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = 1'b0;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        wr_data_d   = '0;
        wr_be_d     = '0;
        hi_data_d   = hi_data_q;
        hi_be_d     = hi_be_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cmd_valid_d = 1'b1;
                    addr_d      = usr_cmd_addr;
                    rnw_d       = usr_cmd_rnw;
                    if (!usr_cmd_rnw) begin
                        wr_data_d = usr_wr_data[BEAT_WIDTH-1:0];
                        wr_be_d   = usr_wr_be[BE_W-1:0];
                        hi_data_d = usr_wr_data[2*BEAT_WIDTH-1:BEAT_WIDTH];
                        hi_be_d   = usr_wr_be[2*BE_W-1:BE_W];
                        state_d   = StWr2;
                    end
                end
            end
            StWr2: begin
                wr_data_d = hi_data_q;
                wr_be_d   = hi_be_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        unique case ({rd_issue, rd_retire})
            2'b10:   rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
            2'b01:   rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
            default: rd_cnt_d = rd_cnt_q;
        endcase
        // Computed from next-state values so the registered ready is exact.
        ready_d = (state_d == StIdle) & phy_rdy & app_fifo_ready & (rd_cnt_d < MAX_CNT);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q     <= StIdle;
            rd_cnt_q    <= '0;
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            wr_data_q   <= '0;
            wr_be_q     <= '0;
            hi_data_q   <= '0;
            hi_be_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            ready_q     <= ready_d;
            cmd_valid_q <= cmd_valid_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            wr_data_q   <= wr_data_d;
            wr_be_q     <= wr_be_d;
            hi_data_q   <= hi_data_d;
            hi_be_q     <= hi_be_d;
        end
    end

    assign usr_cmd_ready = ready_q;
    assign app_cmd_valid = cmd_valid_q;
    assign app_cmd_addr  = addr_q;
    assign app_cmd_rnw   = rnw_q;
    assign app_wr_data   = wr_data_q;
    assign app_wr_be     = wr_be_q;

    dram_rd_assembler #(
        .BEAT_W (BEAT_WIDTH)
    ) u_rd_assembler (
        .clk0          (clk0),
        .rst0          (rst0),
        .app_rd_data   (app_rd_data),
        .app_rd_valid  (app_rd_valid),
        .rd_cnt_zero   (rd_cnt_q == '0),
        .rd_done       (rd_done),
        .usr_rd_data   (usr_rd_data),
        .usr_rd_valid  (usr_rd_valid),
        .rd_unexpected (rd_unexpected)
    );

`ifdef DRAM_SEQ_STATS_EN
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_rd_q, stat_rd_d;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (accept && !usr_cmd_rnw) begin
            stat_wr_d = stat_wr_q + 32'd1;
        end
        if (rd_done) begin
            stat_rd_d = stat_rd_q + 32'd1;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`else
    assign stat_wr_cnt = '0;
    assign stat_rd_cnt = '0;
`endif

endmodule
